// File: rtl/calc_pkg.sv
// Shared definitions for the operand-entry and calculation stages:
// operand/operator widths and the entry-FSM state encoding.
package calc_pkg;

  localparam int OPERAND_W = 4;
  localparam int OP_W      = 3;

  typedef enum logic [1:0] {
    S_A    = 2'd0,
    S_B    = 2'd1,
    S_OP   = 2'd2,
    S_SHOW = 2'd3
  } entry_state_t;

endpackage

// File: rtl/btn_conditioner.sv
// Pushbutton conditioner: 2-flop synchronizer, optional debounce and
// rising-edge detector producing a one-cycle press pulse.
// Debounce is built only with OPERAND_ENTRY_DEBOUNCE_EN defined.
module btn_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);

  logic sync1, sync2;
  logic vld1, vld2;
  logic level, level_q;
  logic armed;

  // Synchronizer chain; vld1/vld2 mark when sync2 holds a real post-reset sample
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      vld1  <= 1'b0;
      vld2  <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      vld1  <= 1'b1;
      vld2  <= vld1;
    end
  end

`ifdef OPERAND_ENTRY_DEBOUNCE_EN
  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt;
  logic             level_r;

  // Accept the synchronized level once it has differed for DEBOUNCE_CYCLES cycles
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      level_r <= 1'b0;
    end else if (sync2 != level_r) begin
      if (cnt == CNT_LAST) begin
        level_r <= sync2;
        cnt     <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      cnt <= '0;
    end
  end

  assign level = level_r;
`else
  assign level = sync2;
`endif

  // Edge detect; a button held through reset stays disarmed until a real low is seen
  always_ff @(posedge clk) begin
    if (reset) begin
      press   <= 1'b0;
      level_q <= 1'b0;
      armed   <= 1'b0;
    end else begin
      press   <= armed & level & ~level_q;
      level_q <= level;
      armed   <= armed | (vld2 & ~sync2);
    end
  end

endmodule

// File: rtl/operand_entry.sv
// Operand entry: collects operand A, operand B and an operator through
// enter/clear pushbuttons and presents the latched triple to the
// calculation stage. Define OPERAND_ENTRY_DEBOUNCE_EN to debounce buttons.
module operand_entry
  import calc_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 btn_enter,
  input  logic                 btn_clear,
  input  logic [OPERAND_W-1:0] sw,
  input  logic [OP_W-1:0]      sw_op,
  output logic [OPERAND_W-1:0] a,
  output logic [OPERAND_W-1:0] b,
  output logic [OP_W-1:0]      op,
  output logic                 valid,
  output logic                 load,
  output logic [1:0]           stage
);

  logic press_enter, press_clear;

  entry_state_t         state, state_nxt;
  logic [OPERAND_W-1:0] a_nxt, b_nxt;
  logic [OP_W-1:0]      op_nxt;
  logic                 valid_nxt, load_nxt;

  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_enter),
    .press (press_enter)
  );

  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_clear),
    .press (press_clear)
  );

  // State and latched-output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_A;
      a     <= '0;
      b     <= '0;
      op    <= '0;
      valid <= 1'b0;
      load  <= 1'b0;
    end else begin
      state <= state_nxt;
      a     <= a_nxt;
      b     <= b_nxt;
      op    <= op_nxt;
      valid <= valid_nxt;
      load  <= load_nxt;
    end
  end

  // Next state and next register values; clear overrides enter
  always_comb begin
    state_nxt = state;
    a_nxt     = a;
    b_nxt     = b;
    op_nxt    = op;
    valid_nxt = valid;
    load_nxt  = 1'b0;
    if (press_clear) begin
      state_nxt = S_A;
      a_nxt     = '0;
      b_nxt     = '0;
      op_nxt    = '0;
      valid_nxt = 1'b0;
    end else if (press_enter) begin
      case (state)
        S_A: begin
          a_nxt     = sw;
          state_nxt = S_B;
        end
        S_B: begin
          b_nxt     = sw;
          state_nxt = S_OP;
        end
        S_OP: begin
          op_nxt    = sw_op;
          valid_nxt = 1'b1;
          load_nxt  = 1'b1;
          state_nxt = S_SHOW;
        end
        default: begin
          valid_nxt = 1'b0;
          state_nxt = S_A;
        end
      endcase
    end
  end

  assign stage = state;

endmodule

// File: doc/operand_entry.md
OPERAND_ENTRY -- requirements
Module: operand_entry

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, the number of consecutive stable clk cycles before a button level is accepted (10 ms at 100 MHz).
REQ-002 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port btn_enter  input  1  raw, asynchronous pushbutton that commits the current field.
REQ-005 SHALL have port btn_clear  input  1  raw, asynchronous pushbutton that aborts entry.
REQ-006 SHALL have port sw  input  4  operand switches.
REQ-007 SHALL have port sw_op  input  3  operator switches.
REQ-008 SHALL have port a  output  4  latched operand A, fed to the calculation stage.
REQ-009 SHALL have port b  output  4  latched operand B.
REQ-010 SHALL have port op  output  3  latched operator code.
REQ-011 SHALL have port valid  output  1  high while a complete a/b/op triple is presented.
REQ-012 SHALL have port load  output  1  one-cycle pulse on the cycle valid rises.
REQ-013 SHALL have port stage  output  2  current entry state, for the LED indicator.

Function
REQ-014 SHALL pass each button through a 2-flop synchronizer before any other use.
REQ-015 SHALL produce press_enter/press_clear as one-cycle pulses on the rising edge of the conditioned level.
REQ-016 SHALL implement FSM states S_A=0, S_B=1, S_OP=2, S_SHOW=3, with stage = current state.
REQ-017 SHALL handle press_enter in S_A as: a<=sw, next state S_B.
REQ-018 SHALL handle press_enter in S_B as: b<=sw, next state S_OP.
REQ-019 SHALL handle press_enter in S_OP as: op<=sw_op, next state S_SHOW, valid<=1, load<=1 for exactly one cycle.
REQ-020 SHALL handle press_enter in S_SHOW as: next state S_A, valid<=0; a/b/op keep their values until overwritten.
REQ-021 SHALL latch registers on the same edge as the state change, so an output is updated one cycle after the press pulse.
REQ-022 SHALL, on press_clear in any state, go to S_A and zero a/b/op/valid/load.
REQ-023 SHALL give press_clear priority over press_enter when both occur in the same cycle.
REQ-024 SHALL ignore switch changes while not on a press pulse.
REQ-025 SHALL produce at most one press pulse per physical press (held button = single pulse).

Reset
REQ-026 SHALL, while reset is high, set state S_A, a=0, b=0, op=0, valid=0, load=0, stage=0, and clear all synchronizer flops, debounce counters and debounced levels.
REQ-027 SHALL, when reset is asserted mid-entry or in S_SHOW, discard the partial triple; a button held through reset release SHALL NOT generate a press until it has been released and pressed again.

Configuration
REQ-028 SHALL, with OPERAND_ENTRY_DEBOUNCE_EN defined, accept a new conditioned level only after the synchronized input has differed from it for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count.
REQ-029 SHALL, with OPERAND_ENTRY_DEBOUNCE_EN undefined, use the synchronized level as the conditioned level; press pulse 3 cycles after the raw rise.

Structure
REQ-030 SHALL take state encodings, OPERAND_W=4 and OP_W=3 from shared package calc_pkg, also used by the calculation stage.
REQ-031 SHALL implement button synchronize/debounce/edge-detect in sub-module btn_conditioner, instantiated once per button.

Verification
REQ-032 SHALL cover, with the macro defined and DEBOUNCE_CYCLES=4: enter presses with sw=3, sw=5, sw_op=2 -> a=3, b=5, op=2, valid=1, one load pulse, stage=3.
REQ-033 SHALL cover: btn_enter bouncing 1-0-1 in 2-cycle bursts, then stable for 10 cycles -> exactly one press; stage advances 0->1 only.
REQ-034 SHALL cover: in S_B, btn_enter and btn_clear rise in the same cycle -> stage=0, a=0, no advance.
REQ-035 SHALL cover: reset pulse in S_OP with a=7, b=9 -> all outputs 0 the next cycle; btn_enter held through reset -> no press until released and pressed again.
REQ-036 SHALL cover: in S_SHOW, toggle sw/sw_op without a press -> a/b/op unchanged; then press enter -> stage=0, valid=0, a/b/op retained.
REQ-037 SHALL cover, with the macro undefined: raw btn_enter rise -> load/state effect visible 4 cycles later; each bounce produces its own press.
